fetch_queue: RTL and testbench

//  Instruction fetch queue between the PC register / instruction memory (IF) and decode (ID).

---
 rtl/fetch_queue.sv | 108 ++++++++++
 tb/tb_fetch_queue.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue between IF and ID: circular buffer of (pc, instr) entries with flush.
// Optional fetch address exceptions are enabled by defining FETCH_EXC_EN.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] ADDR_LO  = 32'h0000_3000,
  parameter logic [31:0] ADDR_HI  = 32'h0000_6FFC
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [31:0]              push_pc,
  input  logic [31:0]              push_instr,
  output logic                     pop_valid,
  input  logic                     pop_ready,
  output logic [31:0]              pop_pc,
  output logic [31:0]              pop_instr,
  output logic [4:0]               pop_exc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] instr_mem [DEPTH];

  logic        push_fire;
  logic        pop_fire;
  logic        addr_bad;
  logic [31:0] store_instr;

  assign addr_bad = (push_pc[1:0] != 2'b00) || (push_pc < ADDR_LO) || (push_pc > ADDR_HI);

`ifdef FETCH_EXC_EN
  logic [4:0] exc_mem [DEPTH];
  logic [4:0] push_exc;

  // A faulting fetch is carried to decode as a nop tagged with AdEL.
  assign push_exc    = addr_bad ? 5'd4 : 5'd0;
  assign store_instr = addr_bad ? 32'h0 : push_instr;
  assign pop_exc     = pop_valid ? exc_mem[head_q] : 5'd0;
`else
  logic unused_addr_bad;

  assign unused_addr_bad = addr_bad;
  assign store_instr     = push_instr;
  assign pop_exc         = 5'd0;
`endif

  assign push_ready = (count_q < FULL);
  assign pop_valid  = (count_q != '0);
  assign count      = count_q;
  assign pop_pc     = pop_valid ? pc_mem[head_q]    : PC_RESET;
  assign pop_instr  = pop_valid ? instr_mem[head_q] : 32'h0;

  always_comb begin
    push_fire = push_valid && push_ready && !flush;
    pop_fire  = pop_valid && pop_ready && !flush;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_fire) tail_d = tail_q + AW'(1);
      if (pop_fire)  head_d = head_q + AW'(1);
      case ({push_fire, pop_fire})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload needs no reset: it is only observed while counted as valid.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      pc_mem[tail_q]    <= push_pc;
      instr_mem[tail_q] <= store_instr;
`ifdef FETCH_EXC_EN
      exc_mem[tail_q]   <= push_exc;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: table-driven vectors plus reset and exception sequences.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        push_valid;
  logic        push_ready;
  logic [31:0] push_pc;
  logic [31:0] push_instr;
  logic        pop_valid;
  logic        pop_ready;
  logic [31:0] pop_pc;
  logic [31:0] pop_instr;
  logic [4:0]  pop_exc;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  fetch_queue dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .push_pc    (push_pc),
    .push_instr (push_instr),
    .pop_valid  (pop_valid),
    .pop_ready  (pop_ready),
    .pop_pc     (pop_pc),
    .pop_instr  (pop_instr),
    .pop_exc    (pop_exc),
    .count      (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic        pv;
    logic [31:0] ppc;
    logic        pr;
    int          ecnt;
    logic        epv;
    logic        eprdy;
    logic [31:0] epc;
  } vec_t;

  vec_t vecs[64];
  int   nvec = 0;

  function automatic logic [31:0] ins(input logic [31:0] pc);
    return 32'hAB00_0000 | pc;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic fl, input logic pv, input logic [31:0] ppc, input logic pr,
                     input int ecnt, input logic epv, input logic eprdy, input logic [31:0] epc);
    vecs[nvec] = '{fl, pv, ppc, pr, ecnt, epv, eprdy, epc};
    nvec++;
  endtask

  logic [31:0] exc_pcs [3];
  logic [31:0] exp_instr;
  logic [4:0]  exp_exc;

  initial begin
    // fill/drain, 5th push blocked, pop on empty ignored
    add(0, 1, 32'h3000, 0, 0, 0, 1, 32'h3000);
    add(0, 1, 32'h3004, 0, 1, 1, 1, 32'h3000);
    add(0, 1, 32'h3008, 0, 2, 1, 1, 32'h3000);
    add(0, 1, 32'h300C, 0, 3, 1, 1, 32'h3000);
    add(0, 1, 32'h3010, 0, 4, 1, 0, 32'h3000);
    add(0, 1, 32'h3010, 1, 4, 1, 0, 32'h3000);
    add(0, 0, 32'h0,    1, 3, 1, 1, 32'h3004);
    add(0, 0, 32'h0,    1, 2, 1, 1, 32'h3008);
    add(0, 0, 32'h0,    1, 1, 1, 1, 32'h300C);
    add(0, 0, 32'h0,    1, 0, 0, 1, 32'h3000);
    // steady stream with one prefill; pointers wrap
    add(0, 1, 32'h3100, 0, 0, 0, 1, 32'h3000);
    for (int k = 0; k < 10; k++)
      add(0, 1, 32'h3104 + 32'(4 * k), 1, 1, 1, 1, 32'h3100 + 32'(4 * k));
    add(0, 0, 32'h0, 0, 1, 1, 1, 32'h3128);
    // flush with 3 held, same-cycle push and pop
    add(0, 1, 32'h3200, 0, 1, 1, 1, 32'h3128);
    add(0, 1, 32'h3204, 0, 2, 1, 1, 32'h3128);
    add(1, 1, 32'h3010, 1, 3, 1, 1, 32'h3128);
    add(0, 0, 32'h0,    0, 0, 0, 1, 32'h3000);
    add(0, 0, 32'h0,    1, 0, 0, 1, 32'h3000);
    add(0, 1, 32'h3300, 0, 0, 0, 1, 32'h3000);
    add(0, 0, 32'h0,    1, 1, 1, 1, 32'h3300);
    add(0, 0, 32'h0,    0, 0, 0, 1, 32'h3000);

    reset = 1'b1; flush = 1'b0; push_valid = 1'b0; push_pc = '0; push_instr = '0; pop_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // reset asserted between edges clears state at once
    push_valid = 1'b1; push_pc = 32'h3040; push_instr = ins(32'h3040);
    @(negedge clk);
    push_pc = 32'h3044; push_instr = ins(32'h3044);
    @(negedge clk);
    push_valid = 1'b0;
    #1 chk("pre_reset_count", 32'(count), 32'd2);
    #1 reset = 1'b1;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_pop_valid", 32'(pop_valid), 32'd0);
    chk("rst_pop_pc", pop_pc, 32'h3000);
    chk("rst_pop_instr", pop_instr, 32'h0);
    chk("rst_pop_exc", 32'(pop_exc), 32'd0);
    chk("rst_push_ready", 32'(push_ready), 32'd1);
    $display("reset mid-cycle: count=%0d pop_valid=%0d pop_pc=%h", count, pop_valid, pop_pc);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < nvec; i++) begin
      @(negedge clk);
      flush = vecs[i].flush; push_valid = vecs[i].pv; push_pc = vecs[i].ppc;
      push_instr = ins(vecs[i].ppc); pop_ready = vecs[i].pr;
      #1;
      exp_instr = vecs[i].epv ? ins(vecs[i].epc) : 32'h0;
      chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].ecnt));
      chk($sformatf("v%0d_pop_valid", i), 32'(pop_valid), 32'(vecs[i].epv));
      chk($sformatf("v%0d_push_ready", i), 32'(push_ready), 32'(vecs[i].eprdy));
      chk($sformatf("v%0d_pop_pc", i), pop_pc, vecs[i].epc);
      chk($sformatf("v%0d_pop_instr", i), pop_instr, exp_instr);
      chk($sformatf("v%0d_pop_exc", i), 32'(pop_exc), 32'd0);
      $display("vec %0d: flush=%0d push=%0d/%h pop_ready=%0d -> count=%0d pop_valid=%0d pop_pc=%h",
               i, flush, push_valid, push_pc, pop_ready, count, pop_valid, pop_pc);
    end

    // exception tagging of misaligned / out-of-range fetches
    exc_pcs[0] = 32'h3002; exc_pcs[1] = 32'h7000; exc_pcs[2] = 32'h3004;
    flush = 1'b0; pop_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      push_valid = 1'b1; push_pc = exc_pcs[k]; push_instr = ins(exc_pcs[k]);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      push_valid = 1'b0; pop_ready = 1'b1;
      #1;
`ifdef FETCH_EXC_EN
      exp_exc   = (k < 2) ? 5'd4 : 5'd0;
      exp_instr = (k < 2) ? 32'h0 : ins(exc_pcs[k]);
`else
      exp_exc   = 5'd0;
      exp_instr = ins(exc_pcs[k]);
`endif
      chk($sformatf("exc%0d_pop_pc", k), pop_pc, exc_pcs[k]);
      chk($sformatf("exc%0d_pop_exc", k), 32'(pop_exc), 32'(exp_exc));
      chk($sformatf("exc%0d_pop_instr", k), pop_instr, exp_instr);
      $display("exc pop %0d: pc=%h exc=%0d instr=%h", k, pop_pc, pop_exc, pop_instr);
    end
    @(negedge clk);
    pop_ready = 1'b0;
    #1 chk("exc_drained", 32'(pop_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
